// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared BCD time types, channel state encoding and BCD helpers
//                for the digital-clock alarm logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
  } bcd_time_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZED = 2'd3
  } ch_state_e;

  localparam logic [7:0] C_BCD_HOUR_MAX   = 8'h23;
  localparam logic [7:0] C_BCD_MINSEC_MAX = 8'h59;

  // Inputs are assumed to be valid two-digit BCD (00..99).
  function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
    return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_bank_bcd_min_add.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_min_add
//  Description : Combinational BCD time + ADD_MIN minutes, with minute->hour
//                carry and 23->00 day wrap. Seconds pass through unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_min_add
  import clock_pkg::*;
#(
  parameter int unsigned ADD_MIN = 5
) (
  input  bcd_time_t i_time,
  output bcd_time_t o_time
);

  localparam logic [6:0] C_MIN_MOD  = bcd_to_bin(C_BCD_MINSEC_MAX) + 7'd1;
  localparam logic [6:0] C_HOUR_MOD = bcd_to_bin(C_BCD_HOUR_MAX) + 7'd1;
  localparam logic [6:0] C_ADD      = 7'(ADD_MIN);

  logic [6:0] w_min_sum;
  logic [6:0] w_hour_sum;
  logic       w_carry;

  always_comb begin
    // ADD_MIN <= 59 keeps the raw sum below 2*60, so one subtraction suffices
    w_min_sum  = bcd_to_bin(i_time.m) + C_ADD;
    w_carry    = (w_min_sum >= C_MIN_MOD);
    if (w_carry) begin
      w_min_sum = w_min_sum - C_MIN_MOD;
    end
    w_hour_sum = bcd_to_bin(i_time.h) + 7'(w_carry);
    if (w_hour_sum >= C_HOUR_MOD) begin
      w_hour_sum = w_hour_sum - C_HOUR_MOD;
    end
    o_time.h = bin_to_bcd(w_hour_sum);
    o_time.m = bin_to_bcd(w_min_sum);
    o_time.s = i_time.s;
  end

endmodule
`default_nettype wire

// File: rtl/alarm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_bank
//  Description : CH_NUM-channel BCD alarm engine with arming, per-second match,
//                lowest-index ring arbitration, ring timeout and optional
//                snooze (compile with ALARM_BANK_SNOOZE_EN to enable snooze).
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_bank
  import clock_pkg::*;
#(
  parameter  int unsigned CH_NUM     = 4,
  parameter  int unsigned RING_SEC   = 60,
  parameter  int unsigned SNOOZE_MIN = 5,
  localparam int unsigned CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              CP,
  input  logic              RST,
  input  logic              TICK,
  input  logic [7:0]        Q_H,
  input  logic [7:0]        Q_M,
  input  logic [7:0]        Q_S,
  input  logic              WR,
  input  logic [CH_W-1:0]   WR_CH,
  input  logic [7:0]        WR_H,
  input  logic [7:0]        WR_M,
  input  logic [7:0]        WR_S,
  input  logic              WR_ARM,
  input  logic              END,
  input  logic              SNOOZE,
  output logic              RING,
  output logic [CH_W-1:0]   RING_CH,
  output logic [CH_NUM-1:0] ARMED,
  output logic [CH_NUM-1:0] PENDING
);

  bcd_time_t         alarm_q [CH_NUM];
  bcd_time_t         alarm_d [CH_NUM];
  ch_state_e         state_q [CH_NUM];
  ch_state_e         state_d [CH_NUM];
  logic [CH_NUM-1:0] armed_q;
  logic [CH_NUM-1:0] armed_d;
  logic [7:0]        ring_cnt_q;
  logic [7:0]        ring_cnt_d;

  bcd_time_t         w_now;
  logic              w_ring_any;
  logic [CH_W-1:0]   w_ring_idx;
  logic [CH_NUM-1:0] w_pend_vec;
  logic [CH_NUM-1:0] w_wr_mask;
  logic [CH_NUM-1:0] w_grant;
  logic              w_found;
  logic              w_timeout;

  assign w_now = {Q_H, Q_M, Q_S};

`ifdef ALARM_BANK_SNOOZE_EN
  bcd_time_t snz_q [CH_NUM];
  bcd_time_t snz_d [CH_NUM];
  bcd_time_t w_snz_time;

  // Only one channel can be ringing, so a single adder serves the whole bank.
  bcd_min_add #(
    .ADD_MIN (SNOOZE_MIN)
  ) u_snz_add (
    .i_time (w_now),
    .o_time (w_snz_time)
  );
`else
  logic unused_snooze;
  assign unused_snooze = SNOOZE;
`endif

  always_comb begin
    w_ring_any = 1'b0;
    w_ring_idx = '0;
    w_pend_vec = '0;
    w_wr_mask  = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (state_q[i] == ST_RINGING) begin
        w_ring_any = 1'b1;
        w_ring_idx = CH_W'(i);
      end
      w_pend_vec[i] = (state_q[i] == ST_PENDING);
      w_wr_mask[i]  = WR && (WR_CH == CH_W'(i));
    end
  end

  // A channel being rewritten this edge cannot win; END with nothing ringing
  // flushes the queue instead of promoting from it.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (!w_found && w_pend_vec[i] && !w_wr_mask[i]) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
    if (w_ring_any || END) begin
      w_grant = '0;
    end
  end

  assign w_timeout = w_ring_any && TICK && (({1'b0, ring_cnt_q} + 9'd1) == 9'(RING_SEC));

  always_comb begin
    ring_cnt_d = ring_cnt_q;
    if (|w_grant) begin
      ring_cnt_d = '0;
    end else if (w_ring_any && TICK) begin
      ring_cnt_d = ring_cnt_q + 8'd1;
    end

    armed_d = armed_q;
    for (int i = 0; i < CH_NUM; i++) begin
      alarm_d[i] = alarm_q[i];
      state_d[i] = state_q[i];
`ifdef ALARM_BANK_SNOOZE_EN
      snz_d[i]   = snz_q[i];
`endif
      if (w_wr_mask[i]) begin
        alarm_d[i] = {WR_H, WR_M, WR_S};
        armed_d[i] = WR_ARM;
        state_d[i] = ST_IDLE;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (TICK && armed_q[i] && (alarm_q[i] == w_now)) begin
              state_d[i] = ST_PENDING;
            end
          end
          ST_PENDING: begin
            if (END && !w_ring_any) begin
              state_d[i] = ST_IDLE;
            end else if (w_grant[i]) begin
              state_d[i] = ST_RINGING;
            end
          end
          ST_RINGING: begin
            if (END) begin
              state_d[i] = ST_IDLE;
            end
`ifdef ALARM_BANK_SNOOZE_EN
            else if (SNOOZE) begin
              state_d[i] = ST_SNOOZED;
              snz_d[i]   = w_snz_time;
            end
`endif
            else if (w_timeout) begin
              state_d[i] = ST_IDLE;
            end
          end
          ST_SNOOZED: begin
`ifdef ALARM_BANK_SNOOZE_EN
            if (TICK && (snz_q[i] == w_now)) begin
              state_d[i] = ST_PENDING;
            end
`else
            state_d[i] = ST_IDLE;
`endif
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      armed_q    <= '0;
      ring_cnt_q <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        alarm_q[i] <= '0;
        state_q[i] <= ST_IDLE;
`ifdef ALARM_BANK_SNOOZE_EN
        snz_q[i]   <= '0;
`endif
      end
    end else begin
      armed_q    <= armed_d;
      ring_cnt_q <= ring_cnt_d;
      for (int i = 0; i < CH_NUM; i++) begin
        alarm_q[i] <= alarm_d[i];
        state_q[i] <= state_d[i];
`ifdef ALARM_BANK_SNOOZE_EN
        snz_q[i]   <= snz_d[i];
`endif
      end
    end
  end

  assign RING    = w_ring_any;
  assign RING_CH = w_ring_idx;
  assign ARMED   = armed_q;
  assign PENDING = w_pend_vec;

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_bank
//  Description : Scoreboard bench for alarm_bank (CH_NUM=4, RING_SEC=3,
//                SNOOZE_MIN=5); snooze checks follow ALARM_BANK_SNOOZE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_bank;

  logic       CP;
  logic       RST;
  logic       TICK;
  logic [7:0] Q_H, Q_M, Q_S;
  logic       WR;
  logic [1:0] WR_CH;
  logic [7:0] WR_H, WR_M, WR_S;
  logic       WR_ARM;
  logic       END;
  logic       SNOOZE;
  logic       RING;
  logic [1:0] RING_CH;
  logic [3:0] ARMED;
  logic [3:0] PENDING;

  alarm_bank #(
    .CH_NUM     (4),
    .RING_SEC   (3),
    .SNOOZE_MIN (5)
  ) dut (
    .CP      (CP),
    .RST     (RST),
    .TICK    (TICK),
    .Q_H     (Q_H),
    .Q_M     (Q_M),
    .Q_S     (Q_S),
    .WR      (WR),
    .WR_CH   (WR_CH),
    .WR_H    (WR_H),
    .WR_M    (WR_M),
    .WR_S    (WR_S),
    .WR_ARM  (WR_ARM),
    .END     (END),
    .SNOOZE  (SNOOZE),
    .RING    (RING),
    .RING_CH (RING_CH),
    .ARMED   (ARMED),
    .PENDING (PENDING)
  );

  typedef struct {
    string      tag;
    logic       ring;
    logic [1:0] ch;
    logic [3:0] armed;
    logic [3:0] pend;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CP) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.tag, ".ring"},  32'(RING),    32'(e.ring));
      chk({e.tag, ".ch"},    32'(RING_CH), 32'(e.ch));
      chk({e.tag, ".armed"}, 32'(ARMED),   32'(e.armed));
      chk({e.tag, ".pend"},  32'(PENDING), 32'(e.pend));
    end
  end

  // Queue the outputs expected after the coming edge, then release pulses.
  task automatic step(input string tag, input logic e_ring, input logic [1:0] e_ch,
                      input logic [3:0] e_arm, input logic [3:0] e_pend);
    sb_q.push_back('{tag, e_ring, e_ch, e_arm, e_pend});
    @(posedge CP);
    #1;
    TICK   = 1'b0;
    WR     = 1'b0;
    END    = 1'b0;
    SNOOZE = 1'b0;
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    Q_H = h;
    Q_M = m;
    Q_S = s;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] h, input logic [7:0] m,
                    input logic [7:0] s, input logic arm);
    WR     = 1'b1;
    WR_CH  = ch;
    WR_H   = h;
    WR_M   = m;
    WR_S   = s;
    WR_ARM = arm;
  endtask

  initial begin
    RST = 1'b1; TICK = 1'b0; WR = 1'b0; END = 1'b0; SNOOZE = 1'b0;
    WR_CH = '0; WR_H = '0; WR_M = '0; WR_S = '0; WR_ARM = 1'b0;
    set_time(8'h00, 8'h00, 8'h00);
    step("rst0", 0, 0, 4'h0, 4'h0);
    step("rst1", 0, 0, 4'h0, 4'h0);
    RST = 1'b0;

    // basic alarm: 2-cycle latency from the matching tick
    wr(0, 8'h07, 8'h00, 8'h00, 1);                step("wr_ch0",     0, 0, 4'h1, 4'h0);
    set_time(8'h06, 8'h59, 8'h59); TICK = 1'b1;   step("pre_match",  0, 0, 4'h1, 4'h0);
    set_time(8'h07, 8'h00, 8'h00); TICK = 1'b1;   step("match_pend", 0, 0, 4'h1, 4'h1);
                                                  step("ring_lat2",  1, 0, 4'h1, 4'h0);

    // timeout after the third tick while ringing
    set_time(8'h07, 8'h00, 8'h01); TICK = 1'b1;   step("to_t1",      1, 0, 4'h1, 4'h0);
                                                  step("to_idle",    1, 0, 4'h1, 4'h0);
    TICK = 1'b1;                                  step("to_t2",      1, 0, 4'h1, 4'h0);
    TICK = 1'b1;                                  step("to_t3",      0, 0, 4'h1, 4'h0);
    TICK = 1'b1;                                  step("to_after",   0, 0, 4'h1, 4'h0);

    // arbitration: two channels match together
    wr(1, 8'h12, 8'h30, 8'h00, 1);                step("wr_ch1",     0, 0, 4'h3, 4'h0);
    wr(2, 8'h12, 8'h30, 8'h00, 1);                step("wr_ch2",     0, 0, 4'h7, 4'h0);
    set_time(8'h12, 8'h30, 8'h00); TICK = 1'b1;   step("arb_pend",   0, 0, 4'h7, 4'h6);
                                                  step("arb_ch1",    1, 1, 4'h7, 4'h4);
    set_time(8'h12, 8'h30, 8'h01); END = 1'b1;    step("arb_end1",   0, 0, 4'h7, 4'h4);
                                                  step("arb_ch2",    1, 2, 4'h7, 4'h0);
    END = 1'b1;                                   step("arb_end2",   0, 0, 4'h7, 4'h0);

    // snooze across the day boundary: 23:58:10 + 5 min = 00:03:10
    wr(3, 8'h23, 8'h58, 8'h10, 1);                step("wr_ch3",     0, 0, 4'hF, 4'h0);
    set_time(8'h23, 8'h58, 8'h10); TICK = 1'b1;   step("snz_pend",   0, 0, 4'hF, 4'h8);
                                                  step("snz_ring",   1, 3, 4'hF, 4'h0);
`ifdef ALARM_BANK_SNOOZE_EN
    SNOOZE = 1'b1;                                step("snz_go",     0, 0, 4'hF, 4'h0);
    set_time(8'h00, 8'h03, 8'h09); TICK = 1'b1;   step("snz_early",  0, 0, 4'hF, 4'h0);
    set_time(8'h00, 8'h03, 8'h10); TICK = 1'b1;   step("snz_match",  0, 0, 4'hF, 4'h8);
                                                  step("snz_rering", 1, 3, 4'hF, 4'h0);
`else
    SNOOZE = 1'b1;                                step("snz_ign",    1, 3, 4'hF, 4'h0);
    set_time(8'h00, 8'h03, 8'h09); TICK = 1'b1;   step("snz_t1",     1, 3, 4'hF, 4'h0);
    set_time(8'h00, 8'h03, 8'h10); TICK = 1'b1;   step("snz_t2",     1, 3, 4'hF, 4'h0);
                                                  step("snz_hold",   1, 3, 4'hF, 4'h0);
`endif
    END = 1'b1;                                   step("snz_end",    0, 0, 4'hF, 4'h0);

    // write to the ringing channel stops it and disarms
    set_time(8'h07, 8'h00, 8'h00); TICK = 1'b1;   step("wwr_pend",   0, 0, 4'hF, 4'h1);
                                                  step("wwr_ring",   1, 0, 4'hF, 4'h0);
    wr(0, 8'h07, 8'h00, 8'h00, 0);                step("wwr_stop",   0, 0, 4'hE, 4'h0);
    TICK = 1'b1;                                  step("wwr_disarm", 0, 0, 4'hE, 4'h0);

    // END with nothing ringing flushes the pending queue
    set_time(8'h12, 8'h30, 8'h00); TICK = 1'b1;   step("clr_pend",   0, 0, 4'hE, 4'h6);
                                                  step("clr_ring1",  1, 1, 4'hE, 4'h4);
    set_time(8'h12, 8'h30, 8'h01); END = 1'b1;    step("clr_end1",   0, 0, 4'hE, 4'h4);
    END = 1'b1;                                   step("clr_flush",  0, 0, 4'hE, 4'h0);
                                                  step("clr_quiet",  0, 0, 4'hE, 4'h0);

    // reset while ringing with a channel queued
    set_time(8'h12, 8'h30, 8'h00); TICK = 1'b1;   step("rr_pend",    0, 0, 4'hE, 4'h6);
                                                  step("rr_ring",    1, 1, 4'hE, 4'h4);
    RST = 1'b1;                                   step("rr_rst",     0, 0, 4'h0, 4'h0);
    RST = 1'b0; TICK = 1'b1;                      step("rr_tick",    0, 0, 4'h0, 4'h0);
                                                  step("rr_quiet",   0, 0, 4'h0, 4'h0);

    @(negedge CP);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
